// File: rtl/tag_shadow_ram.sv
// tag_shadow_ram: byte-granular shadow tag store, one TAG_W tag per data byte.
// Supports READ, WRITE, MERGE (read-modify-write OR) and CLEAR, with a hardware
// clear walk that zeroes every entry after reset or on request.
module tag_shadow_ram #(
    parameter int TAG_W  = 6,
    parameter int ADDR_W = 10,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [1:0]               ReqOp,
    input  logic [1:0]               LoadSelect,
    input  logic [ADDR_W-1:0]        Address,
    input  logic [TAG_W-1:0]         TagIN,
    output logic [LANES*TAG_W-1:0]   TagOUT,
    output logic                     TagValid
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_MERGE = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {INIT, IDLE, MERGE} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]       mem [DEPTH];
    logic [ADDR_W-1:0]      cnt_q;
    logic                   acc;
    logic [ADDR_W-1:0]      base;
    logic [ADDR_W-1:0]      lane_addr [LANES];
    logic [LANES-1:0]       lane_en;
    logic [LANES*TAG_W-1:0] rdata;

    logic [LANES*TAG_W-1:0] old_p1;
    logic [ADDR_W-1:0]      addr_p1;
    logic [TAG_W-1:0]       tag_p1;
    logic [LANES-1:0]       en_p1;

    // Number of lanes touched by a request: 2**LoadSelect, capped at 4 and at LANES.
    function automatic int active_lanes(input logic [1:0] ls);
        int n;
        n = (ls == 2'd0) ? 1 : (ls == 2'd1) ? 2 : 4;
        if (n > LANES) n = LANES;
        return n;
    endfunction

    assign acc = ReqValid & ReqReady;

    // Lane addresses wrap modulo DEPTH; the MERGE commit reuses the captured base address.
    always_comb begin
        base = (state_q == MERGE) ? addr_p1 : Address;
        for (int k = 0; k < LANES; k++) begin
            lane_addr[k] = base + ADDR_W'(k);
        end
    end

    // Lane enables and lane-masked read data for the request being presented.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_en[k] = (k < active_lanes(LoadSelect));
            if (lane_en[k]) rdata[k*TAG_W +: TAG_W] = mem[lane_addr[k]];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    // Next-state and handshake: only IDLE accepts requests.
    always_comb begin
        state_d  = state_q;
        ReqReady = 1'b0;
        case (state_q)
            INIT: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            end
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    if (ReqOp == OP_MERGE)      state_d = MERGE;
                    else if (ReqOp == OP_CLEAR) state_d = INIT;
                end
            end
            MERGE: begin
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // Clear-walk counter and registered read result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            TagOUT   <= '0;
            TagValid <= 1'b0;
        end else begin
            TagValid <= 1'b0;
            if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
            if (acc) begin
                case (ReqOp)
                    OP_READ, OP_MERGE: begin
                        TagOUT   <= rdata;
                        TagValid <= 1'b1;
                    end
                    OP_CLEAR: cnt_q <= '0;
                    default: ;
                endcase
            end
        end
    end

    // p0 -> p1: capture pre-merge tags and request fields for the MERGE commit.
    always_ff @(posedge clk) begin
        if (acc && ReqOp == OP_MERGE) begin
            old_p1  <= rdata;
            addr_p1 <= Address;
            tag_p1  <= TagIN;
            en_p1   <= lane_en;
        end
    end

    // Tag array: clear walk, MERGE commit, or WRITE of the accepted request.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (state_q == MERGE) begin
            for (int k = 0; k < LANES; k++) begin
                if (en_p1[k]) mem[lane_addr[k]] <= old_p1[k*TAG_W +: TAG_W] | tag_p1;
            end
        end else if (acc && ReqOp == OP_WRITE) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_en[k]) mem[lane_addr[k]] <= TagIN;
            end
        end
    end

endmodule

// File: tb/tb_tag_shadow_ram.sv
// Directed bench for tag_shadow_ram (TAG_W=6, ADDR_W=10, LANES=4).
module tb_tag_shadow_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid;
    logic        ReqReady;
    logic [1:0]  ReqOp;
    logic [1:0]  LoadSelect;
    logic [9:0]  Address;
    logic [5:0]  TagIN;
    logic [23:0] TagOUT;
    logic        TagValid;

    int n_cmp = 0;
    int n_bad = 0;

    tag_shadow_ram #(.TAG_W(6), .ADDR_W(10), .LANES(4)) dut (
        .clk(clk), .rst(rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .LoadSelect(LoadSelect), .Address(Address), .TagIN(TagIN),
        .TagOUT(TagOUT), .TagValid(TagValid)
    );

    always #5 clk = ~clk;

    // Called at a negedge: count negedges with ReqReady low (bounded).
    task automatic wait_init(output int n);
        n = 0;
        while (!ReqReady && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Present a request at a negedge once ready; returns 1 ns after the acceptance edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] ls,
                         input logic [9:0] addr, input logic [5:0] tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!ReqReady && w < 3000) begin
            w++;
            @(negedge clk);
        end
        n_cmp++;
        if (!ReqReady) begin
            n_bad++;
            $display("FAIL issue_timeout op=%0d got ReqReady=%b want 1", op, ReqReady);
        end
        ReqValid = 1'b1; ReqOp = op; LoadSelect = ls; Address = addr; TagIN = tag;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; ReqValid = 1'b0; ReqOp = 2'd0; LoadSelect = 2'd0; Address = '0; TagIN = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ReqReady !== 1'b0 || TagValid !== 1'b0 || TagOUT !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b out=%h want 0/0/0", ReqReady, TagValid, TagOUT);
        end
        rst = 1'b0;
        wait_init(n);
        n_cmp++;
        if (n !== 1024) begin n_bad++; $display("FAIL reset_walk_len got %0d want 1024", n); end
        issue(2'd0, 2'd2, 10'h3FC, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== 24'h0 || TagValid !== 1'b1) begin
            n_bad++;
            $display("FAIL read_after_init got out=%h vld=%b want 000000/1", TagOUT, TagValid);
        end
        @(negedge clk);
        n_cmp++;
        if (TagValid !== 1'b0) begin n_bad++; $display("FAIL tagvalid_one_cycle got %b want 0", TagValid); end
    endtask

    task automatic test_write_halfword();
        issue(2'd1, 2'd1, 10'h010, 6'h2A);
        @(negedge clk);
        n_cmp++;
        if (TagValid !== 1'b0 || ReqReady !== 1'b1) begin
            n_bad++;
            $display("FAIL write_flags got vld=%b rdy=%b want 0/1", TagValid, ReqReady);
        end
        issue(2'd0, 2'd2, 10'h010, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h00, 6'h00, 6'h2A, 6'h2A}) begin
            n_bad++;
            $display("FAIL halfword_read got %h want %h", TagOUT, {6'h00, 6'h00, 6'h2A, 6'h2A});
        end
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h00, 6'h00, 6'h2A, 6'h2A} || TagValid !== 1'b0) begin
            n_bad++;
            $display("FAIL tagout_hold got %h vld=%b want 000aaa/0", TagOUT, TagValid);
        end
    endtask

    task automatic test_wrap();
        issue(2'd1, 2'd2, 10'h3FE, 6'h15);
        issue(2'd0, 2'd0, 10'h000, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h00, 6'h00, 6'h00, 6'h15}) begin
            n_bad++;
            $display("FAIL wrap_byte0 got %h want %h", TagOUT, {6'h00, 6'h00, 6'h00, 6'h15});
        end
        issue(2'd0, 2'd0, 10'h3FD, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== 24'h0) begin n_bad++; $display("FAIL wrap_3fd got %h want 000000", TagOUT); end
        issue(2'd0, 2'd3, 10'h3FE, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h15, 6'h15, 6'h15, 6'h15}) begin
            n_bad++;
            $display("FAIL wrap_word got %h want %h", TagOUT, {6'h15, 6'h15, 6'h15, 6'h15});
        end
    endtask

    task automatic test_merge();
        issue(2'd1, 2'd2, 10'h100, 6'h03);
        issue(2'd2, 2'd2, 10'h100, 6'h30);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h03, 6'h03, 6'h03, 6'h03} || TagValid !== 1'b1) begin
            n_bad++;
            $display("FAIL merge_old got %h vld=%b want 0c30c3/1", TagOUT, TagValid);
        end
        n_cmp++;
        if (ReqReady !== 1'b0) begin n_bad++; $display("FAIL merge_busy got rdy=%b want 0", ReqReady); end
        @(negedge clk);
        n_cmp++;
        if (ReqReady !== 1'b1) begin n_bad++; $display("FAIL merge_done got rdy=%b want 1", ReqReady); end
        issue(2'd0, 2'd2, 10'h100, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h33, 6'h33, 6'h33, 6'h33}) begin
            n_bad++;
            $display("FAIL merge_result got %h want %h", TagOUT, {6'h33, 6'h33, 6'h33, 6'h33});
        end
    endtask

    task automatic test_clear();
        int n;
        issue(2'd3, 2'd0, 10'h000, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagValid !== 1'b0) begin n_bad++; $display("FAIL clear_vld got %b want 0", TagValid); end
        wait_init(n);
        n_cmp++;
        if (n !== 1024) begin n_bad++; $display("FAIL clear_walk_len got %0d want 1024", n); end
        issue(2'd0, 2'd2, 10'h100, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== 24'h0) begin n_bad++; $display("FAIL clear_read got %h want 000000", TagOUT); end
        // Restart the walk with rst partway through.
        issue(2'd1, 2'd0, 10'h200, 6'h3F);
        issue(2'd3, 2'd0, 10'h000, 6'h00);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        n_cmp++;
        if (n !== 1024) begin n_bad++; $display("FAIL midwalk_rst_len got %0d want 1024", n); end
        issue(2'd0, 2'd0, 10'h200, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== 24'h0) begin n_bad++; $display("FAIL midwalk_read got %h want 000000", TagOUT); end
    endtask

    task automatic test_reset_mid_merge();
        int n;
        issue(2'd1, 2'd1, 10'h040, 6'h0F);
        issue(2'd2, 2'd1, 10'h040, 6'h30);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (TagValid !== 1'b0 || TagOUT !== 24'h0 || ReqReady !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_merge_outs got vld=%b out=%h rdy=%b want 0/000000/0", TagValid, TagOUT, ReqReady);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        n_cmp++;
        if (n !== 1024) begin n_bad++; $display("FAIL rst_merge_walk got %0d want 1024", n); end
        issue(2'd0, 2'd2, 10'h040, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== 24'h0) begin n_bad++; $display("FAIL rst_merge_read got %h want 000000", TagOUT); end
    endtask

    task automatic test_back_to_back();
        issue(2'd1, 2'd0, 10'h080, 6'h11);
        issue(2'd1, 2'd0, 10'h081, 6'h22);
        issue(2'd1, 2'd1, 10'h082, 6'h05);
        issue(2'd0, 2'd2, 10'h080, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h05, 6'h05, 6'h22, 6'h11}) begin
            n_bad++;
            $display("FAIL b2b_read got %h want %h", TagOUT, {6'h05, 6'h05, 6'h22, 6'h11});
        end
        issue(2'd2, 2'd0, 10'h081, 6'h08);
        issue(2'd0, 2'd1, 10'h080, 6'h00);
        @(negedge clk);
        n_cmp++;
        if (TagOUT !== {6'h00, 6'h00, 6'h2A, 6'h11}) begin
            n_bad++;
            $display("FAIL b2b_merge_byte got %h want %h", TagOUT, {6'h00, 6'h00, 6'h2A, 6'h11});
        end
    endtask

    initial begin
        test_reset();
        test_write_halfword();
        test_wrap();
        test_merge();
        test_clear();
        test_reset_mid_merge();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
